// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle control path.
// Fixed-latency word/half/byte loads and stores with lane merge and error flagging.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clck,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be within 1..15");
  end

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      st;
  logic [3:0]  cnt;
  req_t        rq;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic [31:0]       cur;
  logic [31:0]       merged;
  logic [31:0]       ldata;
  logic              mis;
  logic              oor;
  logic              err;
  logic              commit;

  assign idx    = rq.addr[ADDR_W+1:2];
  assign off    = rq.addr[1:0];
  assign cur    = mem[idx];
  assign oor    = |(rq.addr >> (ADDR_W + 2));
  assign err    = mis | oor;
  assign commit = (st == WAIT) && (cnt == 4'd1);

  // Lane extraction for loads and lane merge for partial stores
  always_comb begin
    mis    = 1'b0;
    ldata  = '0;
    merged = cur;
    case (rq.size)
      2'b00: begin
        mis    = (off != 2'b00);
        ldata  = cur;
        merged = rq.wdata;
      end
      2'b01: begin
        mis   = off[0];
        ldata = {16'b0, cur[{off[1], 4'b0000} +: 16]};
        merged[{off[1], 4'b0000} +: 16] = rq.wdata[15:0];
      end
      2'b10: begin
        ldata = {24'b0, cur[{off, 3'b000} +: 8]};
        merged[{off, 3'b000} +: 8] = rq.wdata[7:0];
      end
      default: begin
        mis = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clck or negedge reset_n) begin
    if (!reset_n) begin
      st        <= IDLE;
      cnt       <= '0;
      rq        <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (req_valid) begin
            rq        <= '{req_write, req_size, req_addr, req_wdata};
            cnt       <= LAT;
            st        <= WAIT;
            req_ready <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            st        <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || rq.write) ? '0 : ldata;
          end
        end
        RESP: begin
          st        <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: begin
          st        <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Array is not reset; an async reset drops st to IDLE, so commit cannot fire
  always_ff @(posedge clck) begin
    if (commit && rq.write && !err) begin
      mem[idx] <= merged;
    end
  end

endmodule
